// File: rtl/ntt_out_buffer.sv
// Captures one N-word NTT result frame from the serial dout stream after a done
// pulse, then drains it over a valid/ready interface in natural or bit-reversed order.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 8
`endif

module ntt_out_buffer #(
  parameter int DATA_W     = `DATA_SIZE_ARB,
  parameter int RING_DEPTH = `RING_DEPTH,
  parameter bit BITREV     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [DATA_W-1:0] dout,
  input  logic              clr_ovr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int N = 1 << RING_DEPTH;
  localparam logic [RING_DEPTH-1:0] LAST_IDX = {RING_DEPTH{1'b1}};

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                 state;
  logic [RING_DEPTH-1:0]  wr_ptr;
  logic [RING_DEPTH-1:0]  rd_ptr;
  logic [RING_DEPTH-1:0]  rd_idx;
  logic [DATA_W-1:0]      mem [N];

  // A done that arrives while a frame is still draining is dropped and only flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) state <= CAPTURE;
        end
        CAPTURE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_IDX) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX) begin
              state  <= IDLE;
              wr_ptr <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (state == DRAIN && done)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset; a new capture overwrites every word.
  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      mem[wr_ptr] <= dout;
  end

  always_comb begin
    rd_idx = rd_ptr;
    if (BITREV) begin
      for (int b = 0; b < RING_DEPTH; b++)
        rd_idx[b] = rd_ptr[RING_DEPTH-1-b];
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = mem[rd_idx];
  assign out_last  = out_valid && (rd_ptr == LAST_IDX);
  assign busy      = (state != IDLE);

endmodule
